mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM stage of the 5-stage pipeline: consumes the EX/MEM register outputs, performs the data-memory
//  access over a req/ack bus, resolves branches, and holds the MEM/WB pipeline register.
//  Multi-cycle memory responses stall the front of the pipeline. stall_o gates the power input of
//  EX/MEM and earlier registers. pc_src_o drives wipe on IF/ID, ID/EX and EX/MEM.
// PARAMETERS
//  DW       32  data width of ALU result, store data, load data
//  TIMEOUT  16  cycles to wait in WAIT for dmem_ack_i before the access is aborted (>=2)
// PORTS
//  clk          in   1   clock; all state updates on the falling edge
//  reset        in   1   synchronous, active-high
//  power        in   1   stage enable; when 0 all state holds and no new request starts
//  control_i    in   8   [0]RegWrite [1]MemtoReg [2]Branch [3]MemRead [4]MemWrite [7:5]reserved
//  pcp_i        in   DW  branch target computed in EX
//  alu_i        in   DW  ALU result / memory address
//  r2_i         in   DW  store data
//  wr_i         in   5   destination register
//  zero_i       in   1   ALU zero flag
//  dmem_req_o   out  1   memory request
//  dmem_we_o    out  1   1=write, 0=read; valid while dmem_req_o=1
//  dmem_addr_o  out  DW  word address {alu_i[DW-1:2],2'b00}
//  dmem_wdata_o out  DW  store data
//  dmem_rdata_i in   DW  load data; valid when dmem_ack_i=1
//  dmem_ack_i   in   1   access complete
//  stall_o      out  1   freeze upstream stages
//  pc_src_o     out  1   branch taken: select pcp_i as next PC and flush upstream
//  target_o     out  DW  = pcp_i
//  wb_ctrl_o    out  2   MEM/WB {MemtoReg,RegWrite}
//  wb_rdata_o   out  DW  MEM/WB load data
//  wb_alu_o     out  DW  MEM/WB ALU result
//  wb_wr_o      out  5   MEM/WB destination register
//  bus_err_o    out  1   sticky flag, set on access timeout
//  misalign_o   out  1   one-cycle pulse on a misaligned access (MEM_ALIGN_CHECK_EN only)
// BEHAVIOUR
//  - Reset: FSM=IDLE, timeout counter=0. dmem_req_o=0. All wb_* outputs=0. bus_err_o=0, misalign_o=0.
//  - memop = power & (control_i[3] | control_i[4]).
//  - FSM IDLE: on memop, enter WAIT. Non-memop instructions pass to MEM/WB in the same edge.
//  - FSM WAIT: dmem_req_o=1. dmem_addr_o, dmem_we_o and dmem_wdata_o stay stable (inputs are frozen by stall).
//    Counter increments once per enabled cycle.
//    - On dmem_ack_i: load rdata into MEM/WB with the instruction, enter IDLE, clear counter.
//    - If the counter reaches TIMEOUT-1 without ack: set bus_err_o, load a bubble
//      (wb_ctrl_o=0), enter IDLE, clear counter.
//  - stall_o = (IDLE & memop) | (WAIT & ~dmem_ack_i & ~timeout). Combinational.
//    Result: a 1-cycle-ack access costs exactly one stall cycle.
//  - MEM/WB loads a bubble (wb_ctrl_o=0; other fields don't-care) while stall_o=1 and power=1.
//    When power=0 it holds its value.
//  - pc_src_o = power & control_i[2] & zero_i. Combinational, independent of FSM state.
//  - A store writes no register: RegWrite comes from control_i unchanged. Reserved bits are ignored.
//  - Ack arriving in IDLE is ignored. Ack and timeout in the same cycle: ack wins, bus_err_o is not set.
//  - Reset mid-access: FSM returns to IDLE and dmem_req_o drops on the next edge.
//    The memory slave must tolerate a dropped request.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//    - memop with alu_i[1:0]!=0 issues no request and does not stall.
//    - misalign_o pulses for 1 cycle and MEM/WB loads a bubble.
//  Undefined: alu_i[1:0] is ignored and misalign_o is tied 0.
// STRUCTURE
//  - pipe_pkg: control-bit index localparams (CTRL_REGWRITE..CTRL_MEMWRITE) and the FSM state typedef
//    {IDLE,WAIT}. Shared with the decoder and the other pipeline registers.
//  - One sub-module, memwb_reg: MEM/WB register with load/bubble/hold inputs.
//  - FSM, counter and branch logic stay in mem_stage.
// TESTING
//  - Non-memop add with control=0x01, alu=0x1234, wr=5 -> next edge: wb_ctrl=01, wb_alu=0x1234, wb_wr=5;
//    stall never asserted.
//  - Load with control=0x0B, alu=0x40, ack on the 1st WAIT cycle with rdata=0xDEADBEEF
//    -> stall 1 cycle; req=1, we=0, addr=0x40; wb_rdata=0xDEADBEEF, wb_ctrl=11.
//  - Store with control=0x10, r2=0xA5, ack delayed 3 cycles -> stall 4 cycles; we=1, wdata=0xA5 stable;
//    wb_ctrl=00.
//  - Load with no ack, TIMEOUT=16 -> req held 16 cycles, then bus_err=1 (sticky), bubble, IDLE;
//    a later reset clears bus_err.
//  - Branch with control=0x04, zero=1, pcp=0x100 -> pc_src=1 and target=0x100 in the same cycle;
//    with zero=0 -> pc_src=0.
//  - Define MEM_ALIGN_CHECK_EN; load with alu=0x42 -> no req, no stall, misalign pulses 1 cycle, bubble.
//    Reset asserted in WAIT -> req=0 after the edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-word bit positions and the MEM-stage FSM states.
// Used by the decoder, the pipeline registers and the MEM stage.
package pipe_pkg;

   localparam int unsigned CTRL_REGWRITE = 0;
   localparam int unsigned CTRL_MEMTOREG = 1;
   localparam int unsigned CTRL_BRANCH   = 2;
   localparam int unsigned CTRL_MEMREAD  = 3;
   localparam int unsigned CTRL_MEMWRITE = 4;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory slave.
interface mem_stage_if #(
   parameter int unsigned DW = 32
);

   logic          dmem_req;
   logic          dmem_we;
   logic [DW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic [DW-1:0] dmem_rdata;
   logic          dmem_ack;

   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_wdata,
      input  dmem_rdata,
      input  dmem_ack
   );

   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_wdata,
      output dmem_rdata,
      output dmem_ack
   );

endinterface

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register, falling-edge clocked. en_i=0 holds; bubble_i clears the
// control field so the write-back stage sees a no-op.
module memwb_reg #(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en_i,
   input  logic          bubble_i,
   input  logic [1:0]    ctrl_i,
   input  logic [DW-1:0] rdata_i,
   input  logic [DW-1:0] alu_i,
   input  logic [4:0]    wr_i,
   output logic [1:0]    ctrl_o,
   output logic [DW-1:0] rdata_o,
   output logic [DW-1:0] alu_o,
   output logic [4:0]    wr_o
);

   logic [1:0]    ctrl_q,  ctrl_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [DW-1:0] alu_q,   alu_d;
   logic [4:0]    wr_q,    wr_d;

   always_comb begin
      ctrl_d  = ctrl_q;
      rdata_d = rdata_q;
      alu_d   = alu_q;
      wr_d    = wr_q;
      if (en_i) begin
         ctrl_d  = bubble_i ? '0 : ctrl_i;
         rdata_d = rdata_i;
         alu_d   = alu_i;
         wr_d    = wr_i;
      end
   end

   always_ff @(negedge clk) begin
      if (reset) begin
         ctrl_q  <= '0;
         rdata_q <= '0;
         alu_q   <= '0;
         wr_q    <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         rdata_q <= rdata_d;
         alu_q   <= alu_d;
         wr_q    <= wr_d;
      end
   end

   assign ctrl_o  = ctrl_q;
   assign rdata_o = rdata_q;
   assign alu_o   = alu_q;
   assign wr_o    = wr_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory access over req/ack with timeout, branch resolve, MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses with a one-cycle misalign_o pulse.
module mem_stage
   import pipe_pkg::*;
#(
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               power,
   input  logic [7:0]         control_i,
   input  logic [DW-1:0]      pcp_i,
   input  logic [DW-1:0]      alu_i,
   input  logic [DW-1:0]      r2_i,
   input  logic [4:0]         wr_i,
   input  logic               zero_i,
   mem_stage_if.master        dmem,
   output logic               stall_o,
   output logic               pc_src_o,
   output logic [DW-1:0]      target_o,
   output logic [1:0]         wb_ctrl_o,
   output logic [DW-1:0]      wb_rdata_o,
   output logic [DW-1:0]      wb_alu_o,
   output logic [4:0]         wb_wr_o,
   output logic               bus_err_o,
   output logic               misalign_o
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             bus_err_q, bus_err_d;
   logic             memop, misalign, start, timeout, abort, bubble;
   logic             unused_ctrl;

   assign memop = power & (control_i[CTRL_MEMREAD] | control_i[CTRL_MEMWRITE]);

`ifdef MEM_ALIGN_CHECK_EN
   logic misalign_q;

   assign misalign = (state_q == IDLE) & memop & (alu_i[1:0] != 2'b00);

   always_ff @(negedge clk) begin
      if (reset) misalign_q <= 1'b0;
      else       misalign_q <= misalign;
   end

   assign misalign_o = misalign_q;
`else
   assign misalign   = 1'b0;
   assign misalign_o = 1'b0;
`endif

   assign start   = (state_q == IDLE) & memop & ~misalign;
   assign timeout = (state_q == WAIT) & (cnt_q == CNT_W'(TIMEOUT - 1));
   // ack beats timeout in the same cycle, so only an unacked timeout aborts
   assign abort   = timeout & ~dmem.dmem_ack;
   assign stall_o = start | ((state_q == WAIT) & ~dmem.dmem_ack & ~timeout);
   assign bubble  = stall_o | abort | misalign;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bus_err_d = bus_err_q;
      if (power) begin
         case (state_q)
            IDLE: begin
               if (start) state_d = WAIT;
            end
            WAIT: begin
               if (dmem.dmem_ack || timeout) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  if (!dmem.dmem_ack) bus_err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(negedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Address/data come straight from EX/MEM, which the stall keeps frozen during WAIT
   assign dmem.dmem_req   = (state_q == WAIT);
   assign dmem.dmem_we    = control_i[CTRL_MEMWRITE];
   assign dmem.dmem_addr  = {alu_i[DW-1:2], 2'b00};
   assign dmem.dmem_wdata = r2_i;

   assign pc_src_o  = power & control_i[CTRL_BRANCH] & zero_i;
   assign target_o  = pcp_i;
   assign bus_err_o = bus_err_q;

   assign unused_ctrl = ^control_i[7:5];

   memwb_reg #(
      .DW(DW)
   ) u_memwb (
      .clk     (clk),
      .reset   (reset),
      .en_i    (power),
      .bubble_i(bubble),
      .ctrl_i  ({control_i[CTRL_MEMTOREG], control_i[CTRL_REGWRITE]}),
      .rdata_i (dmem.dmem_rdata),
      .alu_i   (alu_i),
      .wr_i    (wr_i),
      .ctrl_o  (wb_ctrl_o),
      .rdata_o (wb_rdata_o),
      .alu_o   (wb_alu_o),
      .wr_o    (wb_wr_o)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: expected MEM/WB contents are queued when an
// instruction is driven and compared once the stage releases it.
module tb_mem_stage;

   localparam int unsigned TMO = 16;

   logic        clk, reset, power, zero_i;
   logic [7:0]  control_i;
   logic [31:0] pcp_i, alu_i, r2_i;
   logic [4:0]  wr_i;
   logic        stall_o, pc_src_o, bus_err_o, misalign_o;
   logic [31:0] target_o, wb_rdata_o, wb_alu_o;
   logic [1:0]  wb_ctrl_o;
   logic [4:0]  wb_wr_o;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [1:0]  ctrl;
      logic [31:0] alu;
      logic [4:0]  wr;
      logic [31:0] rdata;
      bit          chk_data;
      bit          chk_rdata;
   } wb_t;

   wb_t sb[$];

   mem_stage_if #(.DW(32)) dmem ();

   mem_stage #(.DW(32), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .reset     (reset),
      .power     (power),
      .control_i (control_i),
      .pcp_i     (pcp_i),
      .alu_i     (alu_i),
      .r2_i      (r2_i),
      .wr_i      (wr_i),
      .zero_i    (zero_i),
      .dmem      (dmem),
      .stall_o   (stall_o),
      .pc_src_o  (pc_src_o),
      .target_o  (target_o),
      .wb_ctrl_o (wb_ctrl_o),
      .wb_rdata_o(wb_rdata_o),
      .wb_alu_o  (wb_alu_o),
      .wb_wr_o   (wb_wr_o),
      .bus_err_o (bus_err_o),
      .misalign_o(misalign_o)
   );

   // falling edge is the active edge; inputs change and outputs are sampled around the rising edge
   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one instruction at a rising edge; ack_at = WAIT cycle carrying the ack (0 = never).
   task automatic run_op(input string tag, input logic [7:0] ctrl, input logic [31:0] alu,
                         input logic [31:0] r2, input logic [31:0] rd, input logic [4:0] wr,
                         input int ack_at, input int exp_stall, input bit exp_err);
      wb_t e;
      int  stalls;
      int  wcyc;
      bit  is_mem;
      bit  aborted;
      control_i = ctrl;
      alu_i     = alu;
      r2_i      = r2;
      wr_i      = wr;
      power     = 1'b1;
      zero_i    = 1'b0;
      dmem.dmem_ack   = 1'b0;
      dmem.dmem_rdata = 32'h0BAD_0BAD;

      is_mem      = ctrl[3] | ctrl[4];
      aborted     = is_mem && (ack_at == 0 || ack_at > TMO);
      e.ctrl      = aborted ? 2'b00 : ctrl[1:0];
      e.alu       = alu;
      e.wr        = wr;
      e.rdata     = rd;
      e.chk_data  = !aborted;
      e.chk_rdata = !aborted && ctrl[3];
      sb.push_back(e);

      stalls = 0;
      wcyc   = 0;
      #1;
      while (stall_o === 1'b1 && wcyc < 40) begin
         stalls++;
         @(posedge clk);
         wcyc++;
         dmem.dmem_ack   = (wcyc == ack_at);
         dmem.dmem_rdata = (wcyc == ack_at) ? rd : 32'h0BAD_0BAD;
         #1;
         chk({tag, "_req"},   {31'b0, dmem.dmem_req}, 32'd1);
         chk({tag, "_we"},    {31'b0, dmem.dmem_we},  {31'b0, ctrl[4]});
         chk({tag, "_addr"},  dmem.dmem_addr,         {alu[31:2], 2'b00});
         chk({tag, "_wdata"}, dmem.dmem_wdata,        r2);
      end
      chk({tag, "_stalls"}, stalls, exp_stall);

      @(negedge clk);
      #1;
      dmem.dmem_ack = 1'b0;
      e = sb.pop_front();
      chk({tag, "_wb_ctrl"}, {30'b0, wb_ctrl_o}, {30'b0, e.ctrl});
      if (e.chk_data) begin
         chk({tag, "_wb_alu"}, wb_alu_o, e.alu);
         chk({tag, "_wb_wr"},  {27'b0, wb_wr_o}, {27'b0, e.wr});
      end
      if (e.chk_rdata) chk({tag, "_wb_rdata"}, wb_rdata_o, e.rdata);
      chk({tag, "_bus_err"}, {31'b0, bus_err_o}, {31'b0, exp_err});
      chk({tag, "_req_idle"}, {31'b0, dmem.dmem_req}, 32'd0);
      @(posedge clk);
   endtask

   initial begin
      reset = 1'b1;
      power = 1'b0;
      zero_i = 1'b0;
      control_i = '0;
      pcp_i = '0;
      alu_i = '0;
      r2_i = '0;
      wr_i = '0;
      dmem.dmem_ack = 1'b0;
      dmem.dmem_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_wb_ctrl",  {30'b0, wb_ctrl_o}, 32'd0);
      chk("rst_wb_alu",   wb_alu_o, 32'd0);
      chk("rst_wb_rdata", wb_rdata_o, 32'd0);
      chk("rst_wb_wr",    {27'b0, wb_wr_o}, 32'd0);
      chk("rst_bus_err",  {31'b0, bus_err_o}, 32'd0);
      chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
      chk("rst_req",      {31'b0, dmem.dmem_req}, 32'd0);
      chk("rst_stall",    {31'b0, stall_o}, 32'd0);
      reset = 1'b0;
      @(posedge clk);

      run_op("add",          8'h01, 32'h0000_1234, 32'h0,  32'h0,         5'd5,  0,  0,  1'b0);
      run_op("load1",        8'h0B, 32'h0000_0040, 32'h0,  32'hDEAD_BEEF, 5'd7,  1,  1,  1'b0);
      run_op("store",        8'h10, 32'h0000_0084, 32'hA5, 32'h0,         5'd0,  4,  4,  1'b0);
      run_op("ack_at_limit", 8'h0B, 32'h0000_0048, 32'h0,  32'h1357_9BDF, 5'd9,  16, 16, 1'b0);
      run_op("rsvd_bits",    8'hE9, 32'h0000_0050, 32'h0,  32'hCAFE_F00D, 5'd11, 2,  2,  1'b0);
`ifndef MEM_ALIGN_CHECK_EN
      run_op("load_unalign", 8'h0B, 32'h0000_0043, 32'h0,  32'h0BB0_0CC0, 5'd2,  1,  1,  1'b0);
`endif
      run_op("timeout",      8'h0B, 32'h0000_004C, 32'h0,  32'h0,         5'd3,  0,  16, 1'b1);
      run_op("add_after_err", 8'h01, 32'h0000_55AA, 32'h0, 32'h0,         5'd12, 0,  0,  1'b1);

      // ack while idle must not start or disturb anything
      control_i = 8'h01;
      alu_i = 32'h0000_0077;
      dmem.dmem_ack = 1'b1;
      #1;
      chk("idle_ack_stall", {31'b0, stall_o}, 32'd0);
      @(negedge clk);
      #1;
      chk("idle_ack_req", {31'b0, dmem.dmem_req}, 32'd0);
      chk("idle_ack_alu", wb_alu_o, 32'h0000_0077);
      dmem.dmem_ack = 1'b0;
      @(posedge clk);

      control_i = 8'h04;
      zero_i = 1'b1;
      pcp_i = 32'h0000_0100;
      #1;
      chk("br_taken",  {31'b0, pc_src_o}, 32'd1);
      chk("br_target", target_o, 32'h0000_0100);
      chk("br_stall",  {31'b0, stall_o}, 32'd0);
      zero_i = 1'b0;
      #1;
      chk("br_not_taken", {31'b0, pc_src_o}, 32'd0);
      power = 1'b0;
      zero_i = 1'b1;
      #1;
      chk("br_unpowered", {31'b0, pc_src_o}, 32'd0);

      // power off: a load neither stalls nor requests, and MEM/WB holds
      control_i = 8'h0B;
      alu_i = 32'h0000_0999;
      zero_i = 1'b0;
      #1;
      chk("pwr0_stall", {31'b0, stall_o}, 32'd0);
      @(negedge clk);
      #1;
      chk("pwr0_hold_alu",  wb_alu_o, 32'h0000_0077);
      chk("pwr0_hold_ctrl", {30'b0, wb_ctrl_o}, 32'd1);
      chk("pwr0_req",       {31'b0, dmem.dmem_req}, 32'd0);
      @(posedge clk);

      // reset during WAIT drops the request and clears the sticky error
      power = 1'b1;
      control_i = 8'h0B;
      alu_i = 32'h0000_0080;
      #1;
      chk("rstw_stall", {31'b0, stall_o}, 32'd1);
      @(posedge clk);
      #1;
      chk("rstw_req_before", {31'b0, dmem.dmem_req}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("rstw_req_after", {31'b0, dmem.dmem_req}, 32'd0);
      chk("rstw_bus_err",   {31'b0, bus_err_o}, 32'd0);
      chk("rstw_wb_ctrl",   {30'b0, wb_ctrl_o}, 32'd0);
      reset = 1'b0;
      control_i = 8'h00;
      @(posedge clk);

      run_op("add_post_rst", 8'h03, 32'h0000_2468, 32'h0, 32'h0, 5'd4, 0, 0, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
      control_i = 8'h0B;
      alu_i = 32'h0000_0042;
      #1;
      chk("mis_stall", {31'b0, stall_o}, 32'd0);
      @(negedge clk);
      #1;
      chk("mis_pulse",   {31'b0, misalign_o}, 32'd1);
      chk("mis_req",     {31'b0, dmem.dmem_req}, 32'd0);
      chk("mis_wb_ctrl", {30'b0, wb_ctrl_o}, 32'd0);
      control_i = 8'h00;
      @(negedge clk);
      #1;
      chk("mis_pulse_end", {31'b0, misalign_o}, 32'd0);
      @(posedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
